// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared types and constants for the programmable counter
//   MODE_WRAP / MODE_SAT  end-of-range behaviour selected by the mode port
//   WIDTH_DEF             default count/limit/step/load width
package prog_counter_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic {MODE_WRAP, MODE_SAT} mode_e;
endpackage

// File: rtl/prog_counter_next.sv
// prog_counter_next: combinational next-count and wrap/overflow event logic
//   i_count    current count (assumed <= i_limit)
//   i_step     increment/decrement magnitude
//   i_limit    terminal value, range is 0..i_limit
//   i_up_down  1 = up, 0 = down
//   i_mode     0 = WRAP, 1 = SAT
//   o_next     next count when enabled
//   o_ovf_evt  up count passed i_limit
//   o_unf_evt  down count passed 0
module prog_counter_next
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_up_down,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_ovf_evt,
  output logic             o_unf_evt
);
  logic [WIDTH:0]   w_c, w_s, w_l, w_lp1, w_sum;
  logic [WIDTH-1:0] w_wrap_up, w_wrap_dn;
  logic             w_sat;
  assign w_c   = {1'b0, i_count};
  assign w_s   = {1'b0, i_step};
  assign w_l   = {1'b0, i_limit};
  assign w_lp1 = w_l + 1'b1;
  assign w_sum = w_c + w_s;
  // the wrap results always land in 0..limit, so the top bit is always zero
  assign w_wrap_up = WIDTH'(w_sum - w_lp1);
  assign w_wrap_dn = WIDTH'(w_c + w_lp1 - w_s);
  // a step wider than the whole range cannot wrap meaningfully: saturate
  assign w_sat = (mode_e'(i_mode) == MODE_SAT) || (w_s > w_lp1);
  always_comb begin
    o_next    = i_count;
    o_ovf_evt = 1'b0;
    o_unf_evt = 1'b0;
    if (i_step != '0) begin
      if (i_up_down) begin
        if (w_sum <= w_l) o_next = w_sum[WIDTH-1:0];
        else begin
          o_ovf_evt = 1'b1;
          o_next    = w_sat ? i_limit : w_wrap_up;
        end
      end else begin
        if (w_c >= w_s) o_next = i_count - i_step;
        else begin
          o_unf_evt = 1'b1;
          o_next    = w_sat ? '0 : w_wrap_dn;
        end
      end
    end
  end
endmodule

// File: rtl/prog_counter.sv
// prog_counter: up/down counter with programmable step, limit, wrap/saturate and sticky flags
//   clk, rst_n  clock, asynchronous active-low reset
//   load_n      synchronous load of data_load (clamped to limit)
//   ce          count enable; up_down, mode, step, limit shape the count
//   clr_flags   synchronous clear of ovf/unf (a same-cycle event wins)
//   count_out   registered count; max_count / zero decode it
//   tc          one-cycle pulse with the first post-wrap/saturate value
//   ovf, unf    sticky overflow / underflow flags
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] data_load,
  input  logic             ce,
  input  logic             up_down,
  input  logic             mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count_out,
  output logic             max_count,
  output logic             zero,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);
  logic [WIDTH-1:0] r_count, w_next, w_load;
  logic             r_tc, r_ovf, r_unf, w_ovf_evt, w_unf_evt, w_clamp, w_cnt;
  prog_counter_next #(.WIDTH(WIDTH)) u_next (
    .i_count(r_count), .i_step(step), .i_limit(limit), .i_up_down(up_down),
    .i_mode(mode), .o_next(w_next), .o_ovf_evt(w_ovf_evt), .o_unf_evt(w_unf_evt)
  );
  assign w_load  = (data_load > limit) ? limit : data_load;
  // a lowered limit pulls the count back into range before counting resumes
  assign w_clamp = r_count > limit;
  assign w_cnt   = load_n && !w_clamp && ce;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= !load_n ? w_load : w_clamp ? limit : ce ? w_next : r_count;
      r_tc    <= w_cnt && (w_ovf_evt || w_unf_evt);
      r_ovf   <= (w_cnt && w_ovf_evt) || (r_ovf && !clr_flags);
      r_unf   <= (w_cnt && w_unf_evt) || (r_unf && !clr_flags);
    end
  end
  assign count_out = r_count;
  assign max_count = r_count == limit;
  assign zero      = r_count == '0;
  assign tc        = r_tc;
  assign ovf       = r_ovf;
  assign unf       = r_unf;
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed-vector self-checking bench for prog_counter (WIDTH = 4)
module tb_prog_counter;
  logic       clk = 1'b0, rst_n = 1'b0, load_n = 1'b1, ce = 1'b0, up_down = 1'b1;
  logic       mode = 1'b0, clr_flags = 1'b0;
  logic [3:0] data_load = '0, step = 4'd1, limit = 4'd9;
  logic [3:0] count_out;
  logic       max_count, zero, tc, ovf, unf;
  int         n_tests = 0, n_fail = 0;

  prog_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_n(load_n), .data_load(data_load), .ce(ce),
    .up_down(up_down), .mode(mode), .step(step), .limit(limit), .clr_flags(clr_flags),
    .count_out(count_out), .max_count(max_count), .zero(zero), .tc(tc), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input bit t, input bit o, input bit u);
    check({tag, ".count"}, 32'(count_out), 32'(c));
    check({tag, ".tc"}, 32'(tc), 32'(t));
    check({tag, ".ovf"}, 32'(ovf), 32'(o));
    check({tag, ".unf"}, 32'(unf), 32'(u));
  endtask

  task automatic do_load(input logic [3:0] v);
    load_n = 1'b0; data_load = v;
    tick;
    load_n = 1'b1;
  endtask

  initial begin
    #2;
    chk("reset", 0, 0, 0, 0);
    check("reset.zero", 32'(zero), 1);
    check("reset.max", 32'(max_count), 0);
    #10 rst_n = 1'b1;
    tick;
    chk("held", 0, 0, 0, 0);
    ce = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick;
      chk($sformatf("wrap_up%0d", i), i, 0, 0, 0);
    end
    check("wrap_up.max9", 32'(max_count), 1);
    tick;
    chk("wrap_up.roll", 0, 1, 1, 0);
    check("wrap_up.zero", 32'(zero), 1);
    tick;
    chk("wrap_up.after", 1, 0, 1, 0);
    ce = 1'b0; clr_flags = 1'b1;
    tick;
    chk("clr1", 1, 0, 0, 0);
    clr_flags = 1'b0;
    do_load(4'd1);
    chk("load1", 1, 0, 0, 0);
    up_down = 1'b0; step = 4'd3; ce = 1'b1;
    tick;
    chk("wrap_dn", 8, 1, 0, 1);
    ce = 1'b0;
    tick;
    chk("wrap_dn.hold", 8, 0, 0, 1);
    limit = 4'd15; mode = 1'b1; up_down = 1'b1;
    do_load(4'd14);
    chk("sat.load", 14, 0, 0, 1);
    ce = 1'b1;
    tick;
    chk("sat1", 15, 1, 1, 1);
    check("sat1.max", 32'(max_count), 1);
    tick;
    chk("sat2", 15, 1, 1, 1);
    ce = 1'b0; clr_flags = 1'b1;
    tick;
    chk("clr2", 15, 0, 0, 0);
    ce = 1'b1;
    tick;
    chk("set_wins", 15, 1, 1, 0);
    ce = 1'b0;
    tick;
    chk("clr3", 15, 0, 0, 0);
    clr_flags = 1'b0; limit = 4'd9; mode = 1'b0;
    do_load(4'd12);
    chk("load_clamp", 9, 0, 0, 0);
    limit = 4'd5;
    tick;
    chk("limit_clamp", 5, 0, 0, 0);
    limit = 4'd3; ce = 1'b1;
    tick;
    chk("clamp_ce", 3, 0, 0, 0);
    step = 4'd0;
    tick;
    chk("step0", 3, 0, 0, 0);
    step = 4'd6; up_down = 1'b0;
    tick;
    chk("illegal_dn", 0, 1, 0, 1);
    up_down = 1'b1;
    tick;
    chk("illegal_up", 3, 1, 1, 1);
    ce = 1'b0; clr_flags = 1'b1; limit = 4'd9;
    do_load(4'd7);
    clr_flags = 1'b0;
    chk("pre_rst", 7, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst", 0, 0, 0, 0);
    check("async_rst.zero", 32'(zero), 1);
    check("async_rst.max", 32'(max_count), 0);
    rst_n = 1'b1; ce = 1'b1; step = 4'd1;
    tick;
    chk("resume", 1, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the count, limit, step and load width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port load_n  input  1  synchronous load, active-low.
REQ-005 The block SHALL have port data_load  input  WIDTH  value to load.
REQ-006 The block SHALL have port ce  input  1  count enable, active-high.
REQ-007 The block SHALL have port up_down  input  1  direction: 1 = up, 0 = down.
REQ-008 The block SHALL have port mode  input  1  end behaviour: 0 = WRAP, 1 = SAT.
REQ-009 The block SHALL have port step  input  WIDTH  increment/decrement magnitude.
REQ-010 The block SHALL have port limit  input  WIDTH  terminal value; count range is 0..limit.
REQ-011 The block SHALL have port clr_flags  input  1  synchronous clear of sticky ovf/unf.
REQ-012 The block SHALL have port count_out  output  WIDTH  registered count.
REQ-013 The block SHALL have port max_count  output  1  combinational, count_out == limit.
REQ-014 The block SHALL have port zero  output  1  combinational, count_out == 0.
REQ-015 The block SHALL have port tc  output  1  registered terminal-count pulse.
REQ-016 The block SHALL have ports ovf and unf  output  1 each  registered sticky overflow/underflow flags.

Function
REQ-017 The next-count priority SHALL be: load_n low > clamp (count_out > limit) > ce high > hold.
REQ-018 On load, count_out SHALL take data_load next cycle, or limit if data_load > limit; tc SHALL be 0 that cycle.
REQ-019 With load_n high and count_out > limit (e.g. limit lowered mid-count), count_out SHALL become limit next cycle, regardless of ce; no flag or tc.
REQ-020 With ce low, count_out, tc-source and flags SHALL hold (tc returns to 0).
REQ-021 Arithmetic SHALL be done in WIDTH+1 bits; step = 0 leaves count_out unchanged, no events.
REQ-022 Up: sum = count+step; if sum <= limit, next = sum; else WRAP: next = sum - (limit+1), SAT: next = limit; either case is an overflow event.
REQ-023 Down: if count >= step, next = count-step; else WRAP: next = count + (limit+1) - step, SAT: next = 0; either case is an underflow event.
REQ-024 step > limit+1 is illegal; behaviour SHALL be the SAT result regardless of mode and both tc and the relevant flag SHALL be raised.
REQ-025 tc SHALL be 1 for exactly one cycle: the cycle in which count_out first shows the post-overflow/underflow value.
REQ-026 ovf/unf SHALL set on their event and clear on clr_flags; simultaneous set and clear SHALL leave the flag set.
REQ-027 In SAT mode, repeated counting at the bound SHALL re-raise tc each enabled cycle.

Reset
REQ-028 rst_n low SHALL immediately (no clock edge) force count_out = 0, tc = 0, ovf = 0, unf = 0; max_count then equals (limit == 0), zero = 1.
REQ-029 Release of rst_n SHALL be synchronised by the integrator; the block SHALL resume counting on the first rising edge with rst_n high.

Structure
REQ-030 A shared package prog_counter_pkg SHALL hold typedef enum logic {MODE_WRAP, MODE_SAT} mode_e and the WIDTH default constant.
REQ-031 A combinational sub-module prog_counter_next SHALL compute next value, ovf_evt and unf_evt; the top holds registers and flags only.
REQ-032 The existing counter interface SHALL be extended (mode, step, limit, clr_flags, tc, ovf, unf, rst_n) and the assertion module updated to match.

Verification (WIDTH = 4)
REQ-033 limit=9, step=1, up, WRAP, ce=1 from 0 -> 0..9 then 0; tc=1 only on the 0 cycle; ovf=1 afterwards.
REQ-034 SAT, limit=15, load 14, step=3, up -> 15, stays 15; max_count=1; tc=1 each enabled cycle; ovf=1.
REQ-035 WRAP, limit=9, count=1, step=3, down -> 8; tc=1 one cycle; unf=1.
REQ-036 limit=9, load 12 -> 9; then limit=5 with ce=0 -> count 5 next cycle, tc=0, flags unchanged.
REQ-037 clr_flags=1 in the same cycle as an overflow event -> ovf stays 1; clr_flags next cycle with no event -> ovf=0.
REQ-038 rst_n driven low mid-cycle at count 7 -> count_out=0, zero=1, flags 0 before the next clk edge.
